// File: rtl/agc_mem_pkg.sv
// Shared definitions for the AGC banked memory slice.
// Holds the octal region boundaries of the 12-bit CPU address space, the
// editing-register addresses, the zero-register address, the physical
// address widths and the region classification produced by the decoder.
package agc_mem_pkg;

  localparam logic [11:0] ERASABLE_SW_BASE  = 12'o1400;
  localparam logic [11:0] FIXED_SW_BASE     = 12'o2000;
  localparam logic [11:0] FIXED_FIXED2_BASE = 12'o4000;
  localparam logic [11:0] FIXED_FIXED3_BASE = 12'o6000;

  localparam logic [11:0] EDIT_CYR  = 12'o20;
  localparam logic [11:0] EDIT_SR   = 12'o21;
  localparam logic [11:0] EDIT_CYL  = 12'o22;
  localparam logic [11:0] EDIT_EDOP = 12'o23;

  // Central register 7 is the hardwired zero register.
  localparam logic [11:0] REG_ZERO = 12'o7;

  // Physical address widths: erasable = bank(3)+offset(8), fixed = bank(6)+offset(10).
  localparam int unsigned E_AW = 11;
  localparam int unsigned F_AW = 16;

  typedef enum logic [1:0] {REG_WIN, EDIT, ERASABLE, FIXED} region_e;

endpackage

// File: rtl/agc_addr_decode.sv
// Combinational AGC address decoder.
// Ports:
//   addr_i       12-bit CPU address
//   ebank_i      erasable bank register
//   fbank_i      fixed bank register
//   super_bank_i superbank bit
//   region_o     access class (register window, editing reg, erasable, fixed)
//   e_addr_o     physical erasable address (bank*256 + offset)
//   f_addr_o     physical fixed address (bank*1024 + offset)
//   f_oob_o      fixed access targets a bank not populated in the rope
module agc_addr_decode
  import agc_mem_pkg::*;
#(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned FBANKS = 40
) (
  input  logic [11:0]     addr_i,
  input  logic [2:0]      ebank_i,
  input  logic [4:0]      fbank_i,
  input  logic            super_bank_i,
  output region_e         region_o,
  output logic [E_AW-1:0] e_addr_o,
  output logic [F_AW-1:0] f_addr_o,
  output logic            f_oob_o
);

  logic [5:0] fbank_phys;

  always_comb begin
    region_o   = ERASABLE;
    e_addr_o   = '0;
    f_addr_o   = '0;
    fbank_phys = '0;

    if (addr_i >= FIXED_FIXED3_BASE) begin
      fbank_phys = 6'd3;
    end else if (addr_i >= FIXED_FIXED2_BASE) begin
      fbank_phys = 6'd2;
    end else if (addr_i >= FIXED_SW_BASE) begin
      // Superbank only redirects banks 030-037 up to 040-047.
      if (super_bank_i && (fbank_i[4:3] == 2'b11)) begin
        fbank_phys = {1'b0, fbank_i} + 6'd8;
      end else begin
        fbank_phys = {1'b0, fbank_i};
      end
    end

    if (addr_i >= FIXED_SW_BASE) begin
      region_o = FIXED;
      f_addr_o = {fbank_phys, addr_i[9:0]};
    end else begin
      if (32'(addr_i) < NREGS) begin
        region_o = REG_WIN;
      end else if ((addr_i >= EDIT_CYR) && (addr_i <= EDIT_EDOP)) begin
        region_o = EDIT;
      end
      // Unswitched erasable 0000-1377 maps straight onto banks 0..2.
      if (addr_i >= ERASABLE_SW_BASE) begin
        e_addr_o = {ebank_i, addr_i[7:0]};
      end else begin
        e_addr_o = {1'b0, addr_i[9:8], addr_i[7:0]};
      end
    end

    f_oob_o = (region_o == FIXED) && (32'(fbank_phys) >= FBANKS);
  end

endmodule

// File: rtl/agc_banked_memory.sv
// AGC banked memory: switched-erasable and fixed (rope) arrays selected by the
// bank registers, a central-register window mirrored from the CPU, editing
// registers, fixed-memory write protection and a rope-load port.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ebank, fbank, super_bank   bank selection
//   req_*                      valid/ready request port (write or read)
//   rsp_valid, rsp_data        read response, one cycle after acceptance
//   regs_in                    live central registers from the CPU
//   reg_wr_*                   register-window write forwarded to the CPU
//   fault                      illegal access pulse
//   load_*                     rope-load port (priority over requests)
module agc_banked_memory
  import agc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned EBANKS = 8,
  parameter int unsigned FBANKS = 40,
  parameter int unsigned NREGS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              ebank,
  input  logic [4:0]              fbank,
  input  logic                    super_bank,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [11:0]             req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic [NREGS*DATA_W-1:0] regs_in,
  output logic                    reg_wr_valid,
  output logic [2:0]              reg_wr_idx,
  output logic [DATA_W-1:0]       reg_wr_data,
  output logic                    fault,
  input  logic                    load_valid,
  input  logic [15:0]             load_addr,
  input  logic [DATA_W-1:0]       load_data
);

  region_e         region;
  logic [E_AW-1:0] e_addr;
  logic [F_AW-1:0] f_addr;
  logic            f_oob;

  agc_addr_decode #(
    .NREGS  (NREGS),
    .FBANKS (FBANKS)
  ) u_decode (
    .addr_i       (req_addr),
    .ebank_i      (ebank),
    .fbank_i      (fbank),
    .super_bank_i (super_bank),
    .region_o     (region),
    .e_addr_o     (e_addr),
    .f_addr_o     (f_addr),
    .f_oob_o      (f_oob)
  );

  logic [DATA_W-1:0] emem [EBANKS*256];
  logic [DATA_W-1:0] fmem [FBANKS*1024];

  logic              accept;
  logic              load_in_range;
  logic              load_ok;
  logic [DATA_W-2:0] w;
  logic [DATA_W-1:0] reg_rd;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              reg_wr_valid_q, reg_wr_valid_d;
  logic [2:0]        reg_wr_idx_q, reg_wr_idx_d;
  logic [DATA_W-1:0] reg_wr_data_q, reg_wr_data_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] cyr_q, cyr_d, sr_q, sr_d, cyl_q, cyl_d, edop_q, edop_d;

  assign req_ready     = !load_valid;
  // Requests seen while reset is high are dropped entirely.
  assign accept        = req_valid && req_ready && !reset;
  assign load_in_range = 32'(load_addr) < FBANKS * 1024;
  assign load_ok       = load_valid && load_in_range && !reset;
  assign w             = req_wdata[DATA_W-2:0];
  assign reg_rd        = (req_addr[2:0] == REG_ZERO[2:0]) ? '0
                       : regs_in[int'(req_addr[2:0])*DATA_W +: DATA_W];

  // Arrays carry no reset so their contents survive it.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      fmem[load_addr] <= load_data;
    end
    if (accept && req_write && (region == ERASABLE)) begin
      emem[e_addr] <= req_wdata;
    end
  end

  always_comb begin
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    reg_wr_valid_d = 1'b0;
    reg_wr_idx_d   = reg_wr_idx_q;
    reg_wr_data_d  = reg_wr_data_q;
    fault_d        = load_valid && !load_in_range;
    cyr_d          = cyr_q;
    sr_d           = sr_q;
    cyl_d          = cyl_q;
    edop_d         = edop_q;

    if (accept) begin
      if (req_write) begin
        case (region)
          REG_WIN: begin
            if (req_addr[2:0] != REG_ZERO[2:0]) begin
              reg_wr_valid_d = 1'b1;
              reg_wr_idx_d   = req_addr[2:0];
              reg_wr_data_d  = req_wdata;
            end
          end
          EDIT: begin
            case (req_addr)
              EDIT_CYR:  cyr_d  = {w[0], w[0], w[DATA_W-2:1]};
              EDIT_SR:   sr_d   = {w[DATA_W-2], w[DATA_W-2], w[DATA_W-2:1]};
              EDIT_CYL:  cyl_d  = {w[DATA_W-3], w[DATA_W-3:0], w[DATA_W-2]};
              EDIT_EDOP: edop_d = {1'b0, w} >> 7;
              default: ;
            endcase
          end
          FIXED:   fault_d = 1'b1;
          default: ;
        endcase
      end else begin
        rsp_valid_d = 1'b1;
        case (region)
          REG_WIN: rsp_data_d = reg_rd;
          EDIT: begin
            case (req_addr)
              EDIT_CYR:  rsp_data_d = cyr_q;
              EDIT_SR:   rsp_data_d = sr_q;
              EDIT_CYL:  rsp_data_d = cyl_q;
              EDIT_EDOP: rsp_data_d = edop_q;
              default:   rsp_data_d = '0;
            endcase
          end
          ERASABLE: rsp_data_d = emem[e_addr];
          FIXED: begin
            if (f_oob) begin
              rsp_data_d = '0;
              fault_d    = 1'b1;
            end else begin
              rsp_data_d = fmem[f_addr];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      reg_wr_valid_q <= 1'b0;
      reg_wr_idx_q   <= '0;
      reg_wr_data_q  <= '0;
      fault_q        <= 1'b0;
      cyr_q          <= '0;
      sr_q           <= '0;
      cyl_q          <= '0;
      edop_q         <= '0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      reg_wr_valid_q <= reg_wr_valid_d;
      reg_wr_idx_q   <= reg_wr_idx_d;
      reg_wr_data_q  <= reg_wr_data_d;
      fault_q        <= fault_d;
      cyr_q          <= cyr_d;
      sr_q           <= sr_d;
      cyl_q          <= cyl_d;
      edop_q         <= edop_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign reg_wr_valid = reg_wr_valid_q;
  assign reg_wr_idx   = reg_wr_idx_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign fault        = fault_q;

endmodule
